// File: rtl/inst_queue_if.sv
// inst_queue_if: valid/ready channel carrying a {pc, inst} pair
interface inst_queue_if #(
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [PC_WIDTH-1:0]   pc;
  logic [DATA_WIDTH-1:0] inst;
  modport master (output valid, pc, inst, input ready);
  modport slave  (input valid, pc, inst, output ready);
endinterface

// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode decoupling FIFO with flush and registered-only ready
module inst_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  inst_queue_if.slave                in_if,
  inst_queue_if.master               out_if,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [AW-1:0]         head, tail;
  logic                  push, pop;
  // ready depends only on occupancy and flush, never on the decode side
  always_comb begin
    in_if.ready  = (count_o != CW'(DEPTH)) && !flush_i;
    out_if.valid = count_o != '0;
    out_if.pc    = out_if.valid ? pc_mem[head] : '0;
    out_if.inst  = out_if.valid ? inst_mem[head] : '0;
    push         = in_if.valid && in_if.ready;
    pop          = out_if.valid && out_if.ready;
  end
  // storage needs no reset; an empty queue masks the head to zero
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= in_if.pc;
      inst_mem[tail] <= in_if.inst;
    end
  end
  // pointers and occupancy; reset and flush both empty the queue and win over push/pop
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head    <= '0;
      tail    <= '0;
      count_o <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count_o <= count_o + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed checks of the fetch-to-decode instruction queue
module tb_inst_queue;
  logic       clk = 0;
  logic       reset = 1;
  logic       flush = 0;
  logic [2:0] count;
  int         n_vec = 0;
  int         n_bad = 0;
  inst_queue_if in_bus ();
  inst_queue_if out_bus ();
  inst_queue dut (
    .clk    (clk),
    .reset  (reset),
    .flush_i(flush),
    .in_if  (in_bus),
    .out_if (out_bus),
    .count_o(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    in_bus.valid = v;
    in_bus.pc    = pc;
    in_bus.inst  = inst;
  endtask
  initial begin
    drive(0, 0, 0);
    out_bus.ready = 0;
    tick();
    tick();
    reset = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_ovalid", out_bus.valid, 0);
    chk("rst_iready", in_bus.ready, 1);
    chk("rst_opc", out_bus.pc, 0);
    chk("rst_oinst", out_bus.inst, 0);
    out_bus.ready = 1;
    drive(1, 32'h0, 32'h00000013);
    tick();
    chk("t1_valid0", out_bus.valid, 1);
    chk("t1_pc0", out_bus.pc, 32'h0);
    chk("t1_inst0", out_bus.inst, 32'h00000013);
    chk("t1_count0", count, 1);
    drive(1, 32'h4, 32'h00100093);
    tick();
    chk("t1_pc4", out_bus.pc, 32'h4);
    chk("t1_inst4", out_bus.inst, 32'h00100093);
    chk("t1_count4", count, 1);
    drive(0, 0, 0);
    tick();
    chk("t1_empty_cnt", count, 0);
    chk("t1_empty_vld", out_bus.valid, 0);
    out_bus.ready = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'(4 * i), 32'h1000 + 32'(i));
      #1;
      chk($sformatf("t2_iready%0d", i), in_bus.ready, i < 4);
      tick();
    end
    chk("t2_count", count, 4);
    chk("t2_iready", in_bus.ready, 0);
    chk("t2_head_pc", out_bus.pc, 32'h0);
    chk("t2_head_inst", out_bus.inst, 32'h1000);
    out_bus.ready = 1;
    drive(1, 32'h10, 32'h2010);
    #1;
    chk("t3_full_iready", in_bus.ready, 0);
    tick();
    chk("t3_count", count, 3);
    chk("t3_iready", in_bus.ready, 1);
    chk("t3_head_pc", out_bus.pc, 32'h4);
    out_bus.ready = 0;
    tick();
    chk("t3_refill", count, 4);
    drive(0, 0, 0);
    out_bus.ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t3_drain_pc%0d", i), out_bus.pc, 32'(4 * i));
      chk($sformatf("t3_drain_inst%0d", i), out_bus.inst, i == 4 ? 32'h2010 : 32'h1000 + 32'(i));
      tick();
    end
    chk("t3_drained", count, 0);
    drive(1, 32'h0, 32'h3000);
    tick();
    for (int i = 1; i < 12; i++) begin
      chk($sformatf("t4_cnt%0d", i), count, 1);
      chk($sformatf("t4_pc%0d", i), out_bus.pc, 32'(4 * (i - 1)));
      chk($sformatf("t4_inst%0d", i), out_bus.inst, 32'h3000 + 32'(i - 1));
      drive(1, 32'(4 * i), 32'h3000 + 32'(i));
      tick();
    end
    drive(0, 0, 0);
    chk("t4_last_pc", out_bus.pc, 32'd44);
    tick();
    chk("t4_empty", count, 0);
    out_bus.ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + 32'(4 * i), 32'h4200 + 32'(i));
      tick();
    end
    chk("t5_count3", count, 3);
    flush = 1;
    out_bus.ready = 1;
    drive(1, 32'h300, 32'h4300);
    #1;
    chk("t5_flush_iready", in_bus.ready, 0);
    tick();
    flush = 0;
    drive(0, 0, 0);
    chk("t5_count", count, 0);
    chk("t5_ovalid", out_bus.valid, 0);
    out_bus.ready = 0;
    drive(1, 32'h100, 32'h4100);
    tick();
    drive(0, 0, 0);
    chk("t5_first_pc", out_bus.pc, 32'h100);
    chk("t5_first_inst", out_bus.inst, 32'h4100);
    drive(1, 32'h104, 32'h4104);
    tick();
    chk("t6_count2", count, 2);
    reset = 1;
    drive(1, 32'h108, 32'h4108);
    tick();
    reset = 0;
    drive(0, 0, 0);
    #1;
    chk("t6_count", count, 0);
    chk("t6_ovalid", out_bus.valid, 0);
    chk("t6_iready", in_bus.ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
